// File: rtl/avg_pkg.sv
// Shared widths, window geometry and types for the moving-average subsystem.
package avg_pkg;
   localparam int DATA_W      = 16;
   localparam int AVG_W       = 32;
   localparam int WINDOW_LOG2 = 3;
   localparam int N           = 1 << WINDOW_LOG2;
   localparam int SUM_W       = DATA_W + WINDOW_LOG2;

   typedef logic [DATA_W-1:0] sample_t;
   typedef logic [SUM_W-1:0]  sum_t;

   // Mean of a full window: truncating shift, then zero-extend to the output width.
   function automatic logic [AVG_W-1:0] sum_to_avg(input sum_t s);
      sum_t w_q;
      w_q = s >> WINDOW_LOG2;
      return AVG_W'(w_q);
   endfunction
endpackage

// File: rtl/clk_rstn_if.sv
// Clock and asynchronous active-low reset bundle shared across the subsystem.
interface clk_rstn_if;
   logic clk_i;
   logic rstn_i;

   modport sink (input clk_i, input rstn_i);
endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous strobe, followed by a one-cycle
// pulse on each synchronized rising edge.
module sync_edge_det (
   input  logic clk_i,
   input  logic rstn_i,
   input  logic async_i,
   output logic pulse_o
);
   logic r_s1;
   logic r_s2;
   logic r_s2_d;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_s2_d <= 1'b0;
      end else begin
         r_s1   <= async_i;
         r_s2   <= r_s1;
         r_s2_d <= r_s2;
      end
   end

   // A strobe held high for many cycles yields exactly one pulse.
   assign pulse_o = r_s2 & ~r_s2_d;
endmodule

// File: rtl/top.sv
// Moving average over the last N samples; each sample is announced by an
// asynchronous strobe and the mean appears on avg_o three clocks after it is sampled.
module top
   import avg_pkg::*;
(
   clk_rstn_if.sink          interf,
   input  logic [DATA_W-1:0] data_i,
   input  logic              data_av_ai,
   output logic [AVG_W-1:0]  avg_o
);
   // Handshake: no ready path. A rising edge of data_av_ai announces one sample;
   // data_i must stay stable until the synchronized pulse has captured it.
   logic             w_take;
   sample_t          r_win [N];
   sum_t             r_sum;
   logic             r_upd;
   logic [AVG_W-1:0] r_avg;

   sync_edge_det u_sync (
      .clk_i   (interf.clk_i),
      .rstn_i  (interf.rstn_i),
      .async_i (data_av_ai),
      .pulse_o (w_take)
   );

   // r_win[0] is the newest sample, r_win[N-1] the one evicted next.
   always_ff @(posedge interf.clk_i or negedge interf.rstn_i) begin
      if (!interf.rstn_i) begin
         for (int i = 0; i < N; i++) r_win[i] <= '0;
         r_sum <= '0;
         r_upd <= 1'b0;
      end else begin
         r_upd <= w_take;
         if (w_take) begin
            for (int i = N-1; i > 0; i--) r_win[i] <= r_win[i-1];
            r_win[0] <= data_i;
            r_sum    <= r_sum + sum_t'(data_i) - sum_t'(r_win[N-1]);
         end
      end
   end

   always_ff @(posedge interf.clk_i or negedge interf.rstn_i) begin
      if (!interf.rstn_i) begin
         r_avg <= '0;
      end else if (r_upd) begin
         r_avg <= sum_to_avg(r_sum);
      end
   end

   assign avg_o = r_avg;
endmodule

// File: tb/tb_top.sv
// Bench for the moving-average top: fixed vector table, hand-written corner
// sequences, and random samples checked against a queue-based window model.
module tb_top;
   import avg_pkg::*;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [AVG_W-1:0]  exp;
   } vec_t;

   clk_rstn_if intf ();

   logic [DATA_W-1:0] data_i;
   logic              data_av_ai;
   logic [AVG_W-1:0]  avg_o;

   int               n_tests = 0;
   int               n_fail  = 0;
   logic [AVG_W-1:0] last_avg;
   int unsigned      win_q[$];
   vec_t             tbl[9];

   top dut (
      .interf     (intf),
      .data_i     (data_i),
      .data_av_ai (data_av_ai),
      .avg_o      (avg_o)
   );

   initial intf.clk_i = 1'b0;
   always #5 intf.clk_i = ~intf.clk_i;

   task automatic check(input string nm, input logic [AVG_W-1:0] act, input logic [AVG_W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic void model_reset();
      win_q = {};
      for (int i = 0; i < N; i++) win_q.push_back(0);
   endfunction

   // Window of the last N samples; mean is the plain sum divided by N, truncated.
   function automatic logic [AVG_W-1:0] model_push(input logic [DATA_W-1:0] d);
      longint unsigned s;
      win_q.push_back(int'(d));
      void'(win_q.pop_front());
      s = 0;
      foreach (win_q[i]) s += win_q[i];
      return AVG_W'(s / N);
   endfunction

   // Raise the strobe for 'hold' clocks; E0 is the first edge after it rises.
   task automatic send(input logic [DATA_W-1:0] d, input int hold,
                       input logic [AVG_W-1:0] exp, input string nm);
      int last_c;
      last_c = (hold > 4) ? hold : 4;
      @(posedge intf.clk_i); #1;
      data_i     = d;
      data_av_ai = 1'b1;
      for (int c = 1; c <= last_c; c++) begin
         @(posedge intf.clk_i); #1;
         if (c == hold) data_av_ai = 1'b0;
         if (c == 3) check({nm, "_lat"}, avg_o, last_avg);
         if (c == 4) begin
            check(nm, avg_o, exp);
            data_i = DATA_W'($urandom);
         end
      end
      repeat (5) @(posedge intf.clk_i);
      #1;
      check({nm, "_stable"}, avg_o, exp);
      last_avg = exp;
   endtask

   initial begin
      logic [DATA_W-1:0] d;
      logic [AVG_W-1:0]  e;

      tbl[0] = '{16'd1500,  32'd187};
      tbl[1] = '{16'd100,   32'd200};
      tbl[2] = '{16'd10,    32'd201};
      tbl[3] = '{16'd40000, 32'd5201};
      tbl[4] = '{16'd300,   32'd5238};
      tbl[5] = '{16'd1100,  32'd5376};
      tbl[6] = '{16'd3500,  32'd5813};
      tbl[7] = '{16'd2000,  32'd6063};
      tbl[8] = '{16'd0,     32'd5876};

      intf.rstn_i = 1'b0;
      data_i      = '0;
      data_av_ai  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         data_av_ai = 1'($urandom);
         data_i     = DATA_W'($urandom);
         @(negedge intf.clk_i);
         check("reset", avg_o, '0);
      end
      data_av_ai = 1'b0;
      @(negedge intf.clk_i);
      intf.rstn_i = 1'b1;
      model_reset();
      last_avg = '0;

      for (int i = 0; i < 9; i++) begin
         void'(model_push(tbl[i].data));
         send(tbl[i].data, 1, tbl[i].exp, $sformatf("seq%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         e = model_push(16'hFFFF);
         send(16'hFFFF, 1, e, $sformatf("sat%0d", i));
      end
      check("sat_full", avg_o, 32'd65535);
      check("sat_upper", {16'd0, avg_o[31:16]}, 32'd0);

      e = model_push(16'd1234);
      send(16'd1234, 20, e, "held");

      for (int i = 0; i < 24; i++) begin
         d = DATA_W'($urandom_range(0, 65535));
         e = model_push(d);
         send(d, $urandom_range(1, 6), e, $sformatf("rnd%0d", i));
      end

      for (int i = 0; i < 5; i++) begin
         d = DATA_W'($urandom_range(0, 65535));
         e = model_push(d);
         send(d, 1, e, $sformatf("pre_rst%0d", i));
      end
      @(posedge intf.clk_i); #3;
      intf.rstn_i = 1'b0;
      #1;
      check("rst_mid", avg_o, '0);
      model_reset();
      last_avg = '0;
      repeat (2) @(posedge intf.clk_i);
      #3;
      intf.rstn_i = 1'b1;
      void'(model_push(16'd800));
      send(16'd800, 1, 32'd100, "post_rst");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
